// File: rtl/poker_pkg.sv
// Shared definitions for the betting-round controller: action codes, blind
// amounts, stage codes, FSM states and saturating money helpers.
package poker_pkg;

  localparam int MONEY_W = 15;
  typedef logic [MONEY_W-1:0] money_t;

  localparam money_t SB_AMT    = 15'd100;
  localparam money_t BB_AMT    = 15'd200;
  localparam money_t MONEY_MAX = '1;

  typedef enum logic [2:0] {
    ACT_CHECK    = 3'd0,
    ACT_CALL     = 3'd1,
    ACT_RAISE2   = 3'd2,
    ACT_RAISE4   = 3'd3,
    ACT_RAISE6   = 3'd4,
    ACT_ALLIN    = 3'd5,
    ACT_FOLD     = 3'd6,
    ACT_FOLD_ALT = 3'd7
  } action_t;

  typedef enum logic [2:0] {
    STG_DEAL  = 3'd0,
    STG_FLOP  = 3'd1,
    STG_TURN  = 3'd2,
    STG_RIVER = 3'd3
  } stage_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLINDS,
    ST_PLAYER,
    ST_CPU_WAIT,
    ST_CPU_ACT,
    ST_SETTLE,
    ST_SHOWDOWN
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE   = 2'b00,
    WIN_PLAYER = 2'b01,
    WIN_CPU    = 2'b10
  } winner_t;

  function automatic money_t sat_add(input money_t a, input money_t b);
    logic [MONEY_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[MONEY_W] ? MONEY_MAX : sum[MONEY_W-1:0];
  endfunction

  function automatic money_t min_money(input money_t a, input money_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic is_fold(input action_t a);
    return (a == ACT_FOLD) || (a == ACT_FOLD_ALT);
  endfunction

  function automatic money_t raise_target(input action_t a);
    case (a)
      ACT_RAISE2: return 15'd400;
      ACT_RAISE4: return 15'd800;
      ACT_RAISE6: return 15'd1200;
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/bet_round_ctrl_if.sv
// Bundles the hand inputs (start, stacks, actions) and the table-state
// outputs of bet_round_ctrl; the controller uses the slave modport.
interface bet_round_ctrl_if import poker_pkg::*; ();

  logic        start;
  money_t      player_money_in;
  money_t      cpu_money_in;
  logic        player_valid;
  logic [2:0]  player_action;
  logic [2:0]  cpu_action;

  logic [2:0]  stage;
  money_t      playermoney;
  money_t      cpumoney;
  money_t      playerBet;
  money_t      computerBet;
  money_t      pot;
  logic        player_turn;
  logic        hand_done;
  logic [1:0]  fold_winner;
  logic        showdown;

  modport master (
    output start, player_money_in, cpu_money_in, player_valid, player_action, cpu_action,
    input  stage, playermoney, cpumoney, playerBet, computerBet, pot,
    input  player_turn, hand_done, fold_winner, showdown
  );

  modport slave (
    input  start, player_money_in, cpu_money_in, player_valid, player_action, cpu_action,
    output stage, playermoney, cpumoney, playerBet, computerBet, pot,
    output player_turn, hand_done, fold_winner, showdown
  );

endinterface

// File: rtl/bet_apply.sv
// Combinational action evaluator: turns one action code plus the acting
// side's bet/stack and the opponent's bet into that side's new bet/stack.
module bet_apply import poker_pkg::*; (
  input  action_t action_i,
  input  money_t  own_bet_i,
  input  money_t  opp_bet_i,
  input  money_t  own_stack_i,
  output money_t  new_bet_o,
  output money_t  new_stack_o
);

  money_t call_amt;
  money_t target;
  money_t delta;
  money_t move;

  // NOTE: every signal gets a value before the case so no path infers a latch.
  always_comb begin
    call_amt = (opp_bet_i > own_bet_i) ? (opp_bet_i - own_bet_i) : '0;
    target   = raise_target(action_i);
    delta    = call_amt;
    case (action_i)
      ACT_RAISE2, ACT_RAISE4, ACT_RAISE6: begin
        if ((target > opp_bet_i) && (target > own_bet_i)) delta = target - own_bet_i;
      end
      ACT_ALLIN:              delta = own_stack_i;
      ACT_FOLD, ACT_FOLD_ALT: delta = '0;
      default:                delta = call_amt;
    endcase
    // Chips moved can never exceed the stack, nor push the bet past 15 bits.
    move        = min_money(delta, own_stack_i);
    move        = min_money(move, MONEY_MAX - own_bet_i);
    new_bet_o   = own_bet_i + move;
    new_stack_o = own_stack_i - move;
  end

endmodule

// File: rtl/bet_round_ctrl.sv
// Heads-up betting-round controller: blinds, alternating actions, settle and
// showdown. Optional BET_TIMEOUT_EN folds the player after TIMEOUT_CYCLES idle.
module bet_round_ctrl import poker_pkg::*;
`ifdef BET_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 10_000_000)
`endif
(
  input logic              clk,
  input logic              reset,
  bet_round_ctrl_if.slave  bus
);

  state_t  state_q, state_d;
  stage_t  stage_q, stage_d;
  winner_t fold_winner_q, fold_winner_d;
  logic    dealer_q, dealer_d;
  money_t  pmoney_q, pmoney_d, cmoney_q, cmoney_d;
  money_t  pbet_q, pbet_d, cbet_q, cbet_d, pot_q, pot_d;
  logic    p_acted_q, p_acted_d, c_acted_q, c_acted_d;
  logic    showdown_q, showdown_d, hand_done_q, hand_done_d;

  logic    act_player, act_cpu, player_go, timeout, other_acted, round_end;
  action_t act_code;
  money_t  own_bet, opp_bet, own_stack, opp_stack, new_bet, new_stack;
  money_t  p_blind, c_blind, pot_all;

  assign act_player = (state_q == ST_PLAYER);
  assign act_cpu    = (state_q == ST_CPU_ACT);

`ifdef BET_TIMEOUT_EN
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_cnt_d = act_player ? (tmo_cnt_q + 24'd1) : 24'd0;
  assign timeout   = act_player && !bus.player_valid && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign player_go   = act_player && (bus.player_valid || timeout);
  assign act_code    = timeout ? ACT_FOLD
                               : action_t'(act_player ? bus.player_action : bus.cpu_action);
  assign own_bet     = act_player ? pbet_q   : cbet_q;
  assign opp_bet     = act_player ? cbet_q   : pbet_q;
  assign own_stack   = act_player ? pmoney_q : cmoney_q;
  assign opp_stack   = act_player ? cmoney_q : pmoney_q;
  assign other_acted = act_player ? c_acted_q : p_acted_q;
  assign p_blind     = min_money(dealer_q ? SB_AMT : BB_AMT, pmoney_q);
  assign c_blind     = min_money(dealer_q ? BB_AMT : SB_AMT, cmoney_q);
  assign pot_all     = sat_add(sat_add(pot_q, pbet_q), cbet_q);

  bet_apply u_apply (
    .action_i    (act_code),
    .own_bet_i   (own_bet),
    .opp_bet_i   (opp_bet),
    .own_stack_i (own_stack),
    .new_bet_o   (new_bet),
    .new_stack_o (new_stack)
  );

  // Round closes on matched bets once both acted (or the opponent is all-in),
  // or when the actor is out of chips without being ahead.
  assign round_end = ((new_bet == opp_bet) && (other_acted || (opp_stack == '0)))
                  || ((new_stack == '0) && (new_bet <= opp_bet));

  always_comb begin
    state_d       = state_q;
    stage_d       = stage_q;
    fold_winner_d = fold_winner_q;
    dealer_d      = dealer_q;
    pmoney_d      = pmoney_q;
    cmoney_d      = cmoney_q;
    pbet_d        = pbet_q;
    cbet_d        = cbet_q;
    pot_d         = pot_q;
    p_acted_d     = p_acted_q;
    c_acted_d     = c_acted_q;
    showdown_d    = showdown_q;
    hand_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pmoney_d      = bus.player_money_in;
          cmoney_d      = bus.cpu_money_in;
          pbet_d        = '0;
          cbet_d        = '0;
          pot_d         = '0;
          stage_d       = STG_DEAL;
          fold_winner_d = WIN_NONE;
          showdown_d    = 1'b0;
          dealer_d      = ~dealer_q;
          state_d       = ST_BLINDS;
        end
      end
      ST_BLINDS: begin
        pbet_d    = p_blind;
        cbet_d    = c_blind;
        pmoney_d  = pmoney_q - p_blind;
        cmoney_d  = cmoney_q - c_blind;
        p_acted_d = 1'b0;
        c_acted_d = 1'b0;
        state_d   = dealer_q ? ST_PLAYER : ST_CPU_WAIT;
      end
      ST_CPU_WAIT: state_d = ST_CPU_ACT;
      ST_PLAYER, ST_CPU_ACT: begin
        if (player_go || act_cpu) begin
          if (is_fold(act_code)) begin
            fold_winner_d = act_player ? WIN_CPU : WIN_PLAYER;
            pot_d         = pot_all;
            pbet_d        = '0;
            cbet_d        = '0;
            hand_done_d   = 1'b1;
            state_d       = ST_IDLE;
          end else begin
            if (act_player) begin
              pbet_d    = new_bet;
              pmoney_d  = new_stack;
              p_acted_d = 1'b1;
            end else begin
              cbet_d    = new_bet;
              cmoney_d  = new_stack;
              c_acted_d = 1'b1;
            end
            state_d = round_end ? ST_SETTLE : (act_player ? ST_CPU_WAIT : ST_PLAYER);
          end
        end
      end
      ST_SETTLE: begin
        pot_d     = pot_all;
        pbet_d    = '0;
        cbet_d    = '0;
        p_acted_d = 1'b0;
        c_acted_d = 1'b0;
        if (stage_q == STG_RIVER) begin
          showdown_d  = 1'b1;
          hand_done_d = 1'b1;
          state_d     = ST_SHOWDOWN;
        end else begin
          stage_d = stage_t'(stage_q + 3'd1);
          // With a side all-in nobody can act, so later stages settle back to back.
          if ((pmoney_q == '0) || (cmoney_q == '0)) state_d = ST_SETTLE;
          else                                      state_d = dealer_q ? ST_CPU_WAIT : ST_PLAYER;
        end
      end
      ST_SHOWDOWN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      stage_q       <= STG_DEAL;
      fold_winner_q <= WIN_NONE;
      dealer_q      <= 1'b0;
      pmoney_q      <= '0;
      cmoney_q      <= '0;
      pbet_q        <= '0;
      cbet_q        <= '0;
      pot_q         <= '0;
      p_acted_q     <= 1'b0;
      c_acted_q     <= 1'b0;
      showdown_q    <= 1'b0;
      hand_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_q       <= stage_d;
      fold_winner_q <= fold_winner_d;
      dealer_q      <= dealer_d;
      pmoney_q      <= pmoney_d;
      cmoney_q      <= cmoney_d;
      pbet_q        <= pbet_d;
      cbet_q        <= cbet_d;
      pot_q         <= pot_d;
      p_acted_q     <= p_acted_d;
      c_acted_q     <= c_acted_d;
      showdown_q    <= showdown_d;
      hand_done_q   <= hand_done_d;
    end
  end

  assign bus.stage       = stage_q;
  assign bus.playermoney = pmoney_q;
  assign bus.cpumoney    = cmoney_q;
  assign bus.playerBet   = pbet_q;
  assign bus.computerBet = cbet_q;
  assign bus.pot         = pot_q;
  assign bus.player_turn = act_player;
  assign bus.hand_done   = hand_done_q;
  assign bus.fold_winner = fold_winner_q;
  assign bus.showdown    = showdown_q;

endmodule
